// File: rtl/counter_pkg.sv
// Shared definitions for the counter_mod up/down modulo counter.
// Direction constants and the default terminal-value helper.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Largest value representable in 'width' bits; the natural terminal value.
  function automatic int default_max_val(input int width);
    return (1 << width) - 1;
  endfunction

endpackage : counter_pkg

// File: rtl/counter_next.sv
// Next-state logic for counter_mod: load clamp, up/down modulo step and wrap flag.
// Purely combinational; saturation is selected by sat_mode (tied low when unused).
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = default_max_val(WIDTH)
) (
  input  logic [WIDTH-1:0] d_out,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] cnt_next,
  output logic             wrap_next
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic at_max;
  logic at_zero;

  assign at_max  = (d_out == MAX_W);
  assign at_zero = (d_out == '0);

  always_comb begin
    cnt_next  = d_out;
    wrap_next = 1'b0;
    if (load) begin
      cnt_next = (load_val > MAX_W) ? MAX_W : load_val;
    end else if (en) begin
      // Terminal compare comes first, so the step itself can never overflow.
      if (up_dn == CNT_UP) begin
        if (at_max) begin
          if (!sat_mode) begin
            cnt_next  = '0;
            wrap_next = 1'b1;
          end
        end else begin
          cnt_next = d_out + ONE_W;
        end
      end else begin
        if (at_zero) begin
          if (!sat_mode) begin
            cnt_next  = MAX_W;
            wrap_next = 1'b1;
          end
        end else begin
          cnt_next = d_out - ONE_W;
        end
      end
    end
  end

endmodule : counter_next

// File: rtl/counter_mod.sv
// Parametrised up/down modulo counter with load, enable, terminal count and wrap pulse.
// Optional saturate-instead-of-wrap mode is enabled by defining COUNTER_SAT_EN.
module counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = default_max_val(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_SAT_EN
  input  logic             sat_mode,
`endif
  output logic [WIDTH-1:0] d_out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] d_out_q;
  logic [WIDTH-1:0] d_out_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             sat_eff;

`ifdef COUNTER_SAT_EN
  assign sat_eff = sat_mode;
`else
  assign sat_eff = 1'b0;
`endif

  counter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .d_out     (d_out_q),
    .en        (en),
    .up_dn     (up_dn),
    .load      (load),
    .load_val  (load_val),
    .sat_mode  (sat_eff),
    .cnt_next  (d_out_d),
    .wrap_next (wrap_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      d_out_q <= d_out_d;
      wrap_q  <= wrap_d;
    end
  end

  // High in the cycle before a wrap would occur in the current direction.
  assign tc = en & ~load &
              (((up_dn == CNT_UP)   & (d_out_q == MAX_W)) |
               ((up_dn == CNT_DOWN) & (d_out_q == '0)));

  assign d_out = d_out_q;
  assign wrap  = wrap_q;

endmodule : counter_mod
